// File: rtl/ysyx_22050598_trap_ctrl_pkg.sv
// ysyx_22050598_trap_ctrl_pkg: CSR addresses, mstatus fields, trap causes and FSM encoding.
package ysyx_22050598_trap_ctrl_pkg;
  localparam int XLEN = 64;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam int MS_MIE    = 3;
  localparam int MS_MPIE   = 7;
  localparam int MS_MPP_LO = 11;
  localparam int MS_MPP_HI = 12;
  localparam int MIE_MTIE  = 7;
  localparam logic [63:0] CAUSE_ECALL_D  = 64'hb;
  localparam logic [63:0] CAUSE_EBREAK_D = 64'h3;
  localparam logic [63:0] CAUSE_MTI_D    = 64'h8000_0000_0000_0007;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_EPC    = 3'd1,
    W_CAUSE  = 3'd2,
    W_STATUS = 3'd3,
    R_STATUS = 3'd4,
    REDIRECT = 3'd5
  } state_e;
endpackage

// File: rtl/ysyx_22050598_trap_tgt_calc.sv
// ysyx_22050598_trap_tgt_calc: redirect target from mtvec (direct/vectored) or mepc.
module ysyx_22050598_trap_tgt_calc #(
  parameter int XLEN = 64
) (
  input  logic            is_irq_i,
  input  logic            is_mret_i,
  input  logic [XLEN-1:0] cause_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic [XLEN-1:0] tgt_o
);
  logic [XLEN-1:0] base;
  logic            unused_cause;
  assign unused_cause = ^cause_i[XLEN-1:XLEN-2];
  // Modes 2/3 are reserved and fall back to direct.
  always_comb begin
    base  = {mtvec_i[XLEN-1:2], 2'b00};
    tgt_o = is_mret_i ? {mepc_i[XLEN-1:2], 2'b00}
          : (is_irq_i && mtvec_i[1:0] == 2'b01) ? base + {cause_i[XLEN-3:0], 2'b00}
          : base;
  end
endmodule

// File: rtl/ysyx_22050598_trap_ctrl.sv
// ysyx_22050598_trap_ctrl: sequences M-mode trap entry and mret via one CSR write port, then redirects fetch.
module ysyx_22050598_trap_ctrl
  import ysyx_22050598_trap_ctrl_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] CAUSE_ECALL  = CAUSE_ECALL_D,
  parameter logic [XLEN-1:0] CAUSE_EBREAK = CAUSE_EBREAK_D,
  parameter logic [XLEN-1:0] CAUSE_MTI    = CAUSE_MTI_D
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic            ex_inst_is_ecall_i,
  input  logic            ex_inst_is_ebreak_i,
  input  logic            ex_inst_is_mret_i,
  input  logic            irq_mtip_i,
  input  logic [XLEN-1:0] csr_mstatus_i,
  input  logic [XLEN-1:0] csr_mie_i,
  input  logic [XLEN-1:0] csr_mtvec_i,
  input  logic [XLEN-1:0] csr_mepc_i,
  output logic            trap_busy_o,
  output logic            csr_wr_en_o,
  output logic [11:0]     csr_wr_addr_o,
  output logic [XLEN-1:0] csr_wr_data_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  input  logic            redirect_ready_i
);
  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, cause_q, cause_d, status_q, status_d, tgt_q, tgt_d;
  logic [XLEN-1:0] sel_cause, tgt, st_trap, st_ret;
  logic            irq_take, ecall_take, ebreak_take, mret_take, trap_take, ret_take, any_take;
  logic            unused_mie;
  assign unused_mie = ^{csr_mie_i[XLEN-1:MIE_MTIE+1], csr_mie_i[MIE_MTIE-1:0]};
  // Qualifiers are gated by rst so every output reads 0 while in reset.
  always_comb begin
    irq_take    = rst & ex_valid_i & irq_mtip_i & csr_mstatus_i[MS_MIE] & csr_mie_i[MIE_MTIE];
    ecall_take  = rst & ex_valid_i & ex_inst_is_ecall_i;
    ebreak_take = rst & ex_valid_i & ex_inst_is_ebreak_i;
    mret_take   = rst & ex_valid_i & ex_inst_is_mret_i;
    trap_take   = irq_take | ecall_take | ebreak_take;
    ret_take    = mret_take & ~trap_take;
    any_take    = (state_q == IDLE) & (trap_take | ret_take);
    sel_cause   = irq_take ? CAUSE_MTI : ecall_take ? CAUSE_ECALL : CAUSE_EBREAK;
  end
  ysyx_22050598_trap_tgt_calc #(.XLEN(XLEN)) u_tgt (
    .is_irq_i (irq_take),
    .is_mret_i(ret_take),
    .cause_i  (sel_cause),
    .mtvec_i  (csr_mtvec_i),
    .mepc_i   (csr_mepc_i),
    .tgt_o    (tgt)
  );
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cause_d  = cause_q;
    status_d = status_q;
    tgt_d    = tgt_q;
    case (state_q)
      IDLE: if (any_take) begin
        state_d  = trap_take ? W_EPC : R_STATUS;
        pc_d     = ex_pc_i;
        cause_d  = sel_cause;
        status_d = csr_mstatus_i;
        tgt_d    = tgt;
      end
      W_EPC:    state_d = W_CAUSE;
      W_CAUSE:  state_d = W_STATUS;
      W_STATUS: state_d = REDIRECT;
      R_STATUS: state_d = REDIRECT;
      REDIRECT: state_d = redirect_ready_i ? IDLE : REDIRECT;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      cause_q  <= '0;
      status_q <= '0;
      tgt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cause_q  <= cause_d;
      status_q <= status_d;
      tgt_q    <= tgt_d;
    end
  end
  always_comb begin
    st_trap                       = status_q;
    st_trap[MS_MPIE]              = status_q[MS_MIE];
    st_trap[MS_MIE]               = 1'b0;
    st_trap[MS_MPP_HI:MS_MPP_LO]  = 2'b11;
    st_ret                        = status_q;
    st_ret[MS_MIE]                = status_q[MS_MPIE];
    st_ret[MS_MPIE]               = 1'b1;
    st_ret[MS_MPP_HI:MS_MPP_LO]   = 2'b11;
    trap_busy_o      = (state_q != IDLE) | any_take;
    csr_wr_en_o      = state_q inside {W_EPC, W_CAUSE, W_STATUS, R_STATUS};
    csr_wr_addr_o    = state_q == W_EPC ? CSR_MEPC
                     : state_q == W_CAUSE ? CSR_MCAUSE
                     : (state_q == W_STATUS || state_q == R_STATUS) ? CSR_MSTATUS
                     : 12'h0;
    csr_wr_data_o    = state_q == W_EPC ? pc_q
                     : state_q == W_CAUSE ? cause_q
                     : state_q == W_STATUS ? st_trap
                     : state_q == R_STATUS ? st_ret
                     : '0;
    redirect_valid_o = state_q == REDIRECT;
    redirect_pc_o    = state_q == REDIRECT ? tgt_q : '0;
  end
endmodule

// File: tb/tb_ysyx_22050598_trap_ctrl.sv
// tb_ysyx_22050598_trap_ctrl: directed checks of trap entry, mret, irq gating, stall and reset abort.
module tb_ysyx_22050598_trap_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid_i = 1'b0, ex_inst_is_ecall_i = 1'b0, ex_inst_is_ebreak_i = 1'b0, ex_inst_is_mret_i = 1'b0;
  logic        irq_mtip_i = 1'b0, redirect_ready_i = 1'b0;
  logic [63:0] ex_pc_i = '0, csr_mstatus_i = '0, csr_mie_i = '0, csr_mtvec_i = '0, csr_mepc_i = '0;
  logic        trap_busy_o, csr_wr_en_o, redirect_valid_o;
  logic [11:0] csr_wr_addr_o;
  logic [63:0] csr_wr_data_o, redirect_pc_o;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_22050598_trap_ctrl dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i),
    .ex_inst_is_ecall_i(ex_inst_is_ecall_i), .ex_inst_is_ebreak_i(ex_inst_is_ebreak_i),
    .ex_inst_is_mret_i(ex_inst_is_mret_i), .irq_mtip_i(irq_mtip_i),
    .csr_mstatus_i(csr_mstatus_i), .csr_mie_i(csr_mie_i),
    .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i),
    .trap_busy_o(trap_busy_o), .csr_wr_en_o(csr_wr_en_o),
    .csr_wr_addr_o(csr_wr_addr_o), .csr_wr_data_o(csr_wr_data_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .redirect_ready_i(redirect_ready_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(negedge clk);
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic expect_write(input string tag, input logic [11:0] addr, input logic [63:0] data);
    chk({tag, "_busy"}, 64'(trap_busy_o), 64'd1);
    chk({tag, "_wen"}, 64'(csr_wr_en_o), 64'd1);
    chk({tag, "_addr"}, 64'(csr_wr_addr_o), 64'(addr));
    chk({tag, "_data"}, csr_wr_data_o, data);
    chk({tag, "_rv"}, 64'(redirect_valid_o), 64'd0);
  endtask

  task automatic expect_redirect(input string tag, input logic [63:0] pc);
    chk({tag, "_busy"}, 64'(trap_busy_o), 64'd1);
    chk({tag, "_wen"}, 64'(csr_wr_en_o), 64'd0);
    chk({tag, "_rv"}, 64'(redirect_valid_o), 64'd1);
    chk({tag, "_rpc"}, redirect_pc_o, pc);
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_busy"}, 64'(trap_busy_o), 64'd0);
    chk({tag, "_wen"}, 64'(csr_wr_en_o), 64'd0);
    chk({tag, "_addr"}, 64'(csr_wr_addr_o), 64'd0);
    chk({tag, "_data"}, csr_wr_data_o, 64'd0);
    chk({tag, "_rv"}, 64'(redirect_valid_o), 64'd0);
    chk({tag, "_rpc"}, redirect_pc_o, 64'd0);
  endtask

  task automatic clear_ex;
    ex_valid_i = 0; ex_inst_is_ecall_i = 0; ex_inst_is_ebreak_i = 0; ex_inst_is_mret_i = 0;
  endtask

  initial begin
    cyc; settle;
    expect_idle("reset");
    cyc; rst = 1; settle;
    expect_idle("post_reset");

    // ecall, direct mtvec
    cyc; ex_valid_i = 1; ex_inst_is_ecall_i = 1; ex_pc_i = 64'h8000_0010;
    csr_mtvec_i = 64'h8000_1000; csr_mstatus_i = 64'h8; redirect_ready_i = 1; settle;
    chk("ecall_accept_busy", 64'(trap_busy_o), 64'd1);
    chk("ecall_accept_wen", 64'(csr_wr_en_o), 64'd0);
    cyc; clear_ex; settle; expect_write("ecall_epc", 12'h341, 64'h8000_0010);
    cyc; settle; expect_write("ecall_cause", 12'h342, 64'hb);
    cyc; settle; expect_write("ecall_status", 12'h300, 64'h1880);
    cyc; settle; expect_redirect("ecall_redir", 64'h8000_1000);
    cyc; settle; expect_idle("ecall_done");

    // mret; low mepc bits are masked
    cyc; ex_valid_i = 1; ex_inst_is_mret_i = 1; csr_mepc_i = 64'h8000_0017; csr_mstatus_i = 64'h80; settle;
    chk("mret_accept_busy", 64'(trap_busy_o), 64'd1);
    cyc; clear_ex; settle; expect_write("mret_status", 12'h300, 64'h1888);
    cyc; settle; expect_redirect("mret_redir", 64'h8000_0014);
    cyc; settle; expect_idle("mret_done");

    // irq beats concurrent ecall, vectored mtvec
    cyc; ex_valid_i = 1; ex_inst_is_ecall_i = 1; ex_pc_i = 64'h100; irq_mtip_i = 1;
    csr_mie_i = 64'h80; csr_mstatus_i = 64'h8; csr_mtvec_i = 64'h8000_1001; settle;
    chk("irq_accept_busy", 64'(trap_busy_o), 64'd1);
    cyc; clear_ex; irq_mtip_i = 0; settle; expect_write("irq_epc", 12'h341, 64'h100);
    cyc; settle; expect_write("irq_cause", 12'h342, 64'h8000_0000_0000_0007);
    cyc; settle; expect_write("irq_status", 12'h300, 64'h1880);
    cyc; settle; expect_redirect("irq_redir", 64'h8000_101C);
    cyc; settle; expect_idle("irq_done");

    // ebreak beats mret; vectored mode only offsets interrupts
    cyc; ex_valid_i = 1; ex_inst_is_ebreak_i = 1; ex_inst_is_mret_i = 1; ex_pc_i = 64'h200;
    csr_mtvec_i = 64'h8000_2001; csr_mstatus_i = 64'h0; settle;
    chk("ebrk_accept_busy", 64'(trap_busy_o), 64'd1);
    cyc; clear_ex; settle; expect_write("ebrk_epc", 12'h341, 64'h200);
    cyc; settle; expect_write("ebrk_cause", 12'h342, 64'h3);
    cyc; settle; expect_write("ebrk_status", 12'h300, 64'h1800);
    cyc; settle; expect_redirect("ebrk_redir", 64'h8000_2000);
    cyc; settle; expect_idle("ebrk_done");

    // irq masked by MIE=0, then taken once MIE=1; redirect stalled 3 cycles
    cyc; ex_valid_i = 1; irq_mtip_i = 1; csr_mstatus_i = 64'h0; csr_mie_i = 64'h80;
    csr_mtvec_i = 64'h8000_1000; ex_pc_i = 64'h300; redirect_ready_i = 0; settle;
    expect_idle("masked0");
    cyc; settle; expect_idle("masked1");
    cyc; csr_mstatus_i = 64'h8; settle;
    chk("unmask_accept_busy", 64'(trap_busy_o), 64'd1);
    cyc; ex_valid_i = 0; settle; expect_write("unmask_epc", 12'h341, 64'h300);
    cyc; settle; expect_write("unmask_cause", 12'h342, 64'h8000_0000_0000_0007);
    cyc; settle; expect_write("unmask_status", 12'h300, 64'h1880);
    for (int i = 0; i < 3; i++) begin
      cyc; ex_valid_i = 1; ex_inst_is_ecall_i = i[0]; irq_mtip_i = ~i[0]; ex_pc_i = 64'h999; settle;
      expect_redirect("stall", 64'h8000_1000);
    end
    cyc; clear_ex; irq_mtip_i = 0; redirect_ready_i = 1; settle;
    expect_redirect("stall_ready", 64'h8000_1000);
    cyc; settle; expect_idle("stall_done");

    // reset during W_CAUSE abandons the sequence
    cyc; ex_valid_i = 1; ex_inst_is_ecall_i = 1; ex_pc_i = 64'h400; csr_mstatus_i = 64'h8; settle;
    chk("rst_accept_busy", 64'(trap_busy_o), 64'd1);
    cyc; clear_ex; settle; expect_write("rst_epc", 12'h341, 64'h400);
    cyc; settle; expect_write("rst_cause", 12'h342, 64'hb);
    #1 rst = 0; #1;
    expect_idle("rst_async");
    cyc; rst = 1; settle; expect_idle("rst_rel0");
    cyc; settle; expect_idle("rst_rel1");
    cyc; settle; expect_idle("rst_rel2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
